// File: rtl/prmcu_uart_tx_if.sv
// prmcu_uart_tx_if: byte handshake between a byte source and the UART transmitter.
//   dat_i  byte offered by the source
//   vld_i  dat_i is valid
//   rdy_o  transmitter can accept a byte (holding register empty)
// master = byte source, slave = transmitter.
interface prmcu_uart_tx_if #(
  parameter int N_BITS = 8
) ();
  logic [N_BITS-1:0] dat_i;
  logic              vld_i;
  logic              rdy_o;

  modport master (output dat_i, output vld_i, input rdy_o);
  modport slave  (input dat_i, input vld_i, output rdy_o);
endinterface

// File: rtl/prmcu_uart_tx.sv
// prmcu_uart_tx: UART transmitter with a one-entry holding register.
// Frame: start bit, N_BITS data bits LSB first, optional parity, 1 or 2 stop bits.
// Every bit lasts CLKS_PER_BIT clocks.
// Ports:
//   clk            system clock
//   rst            synchronous reset, active-high
//   bus            byte handshake (slave modport: dat_i, vld_i in; rdy_o out)
//   parity_mode_i  00 none, 01 even, 10 odd, 11 none (latched at frame start)
//   stop_bits_i    0 = one stop bit, 1 = two (latched at frame start)
//   tx_o           serial line, idles high, driven from a register
//   busy_o         high while a frame is on the line
//
// state  | meaning
// IDLE   | line high, waiting for the holding register to fill
// START  | start bit (low)
// DATA   | data bits, LSB first
// PARITY | parity bit (only when latched mode is even or odd)
// STOP   | one or two stop bit periods (high)
module prmcu_uart_tx #(
  parameter int CLKS_PER_BIT = 87,
  parameter int N_BITS       = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  prmcu_uart_tx_if.slave        bus,
  input  logic [1:0]            parity_mode_i,
  input  logic                  stop_bits_i,
  output logic                  tx_o,
  output logic                  busy_o
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = $clog2(N_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t            state;
  logic [N_BITS-1:0] hold_data;
  logic              hold_full;
  logic              rdy;
  logic [N_BITS-1:0] shift;
  logic [CNT_W-1:0]  clk_cnt;
  logic [IDX_W-1:0]  bit_idx;
  logic              par_en;
  logic              par_bit;
  logic              stop2;
  logic              stop_idx;
  logic              tx;
  logic              busy;

  logic bit_done;
  logic last_stop;
  logic load;

  assign bit_done  = (clk_cnt == CNT_LAST);
  assign last_stop = (state == STOP) && bit_done && (!stop2 || stop_idx);
  // A frame starts either from IDLE or straight out of the final stop bit,
  // which is what gives back-to-back frames with no idle gap.
  assign load      = hold_full && ((state == IDLE) || last_stop);

  assign bus.rdy_o = rdy;
  assign tx_o      = tx;
  assign busy_o    = busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      hold_data <= '0;
      hold_full <= 1'b0;
      rdy       <= 1'b1;
      shift     <= '0;
      clk_cnt   <= '0;
      bit_idx   <= '0;
      par_en    <= 1'b0;
      par_bit   <= 1'b0;
      stop2     <= 1'b0;
      stop_idx  <= 1'b0;
      tx        <= 1'b1;
      busy      <= 1'b0;
    end else begin
      if (load) begin
        state     <= START;
        shift     <= hold_data;
        par_en    <= ^parity_mode_i;
        // even: bit makes the ones count even; odd: inverted
        par_bit   <= (^hold_data) ^ (parity_mode_i == 2'b10);
        stop2     <= stop_bits_i;
        hold_full <= 1'b0;
        rdy       <= 1'b1;
        clk_cnt   <= '0;
        bit_idx   <= '0;
        stop_idx  <= 1'b0;
        tx        <= 1'b0;
        busy      <= 1'b1;
      end else begin
        if (state != IDLE) begin
          clk_cnt <= bit_done ? '0 : clk_cnt + CNT_W'(1);
        end
        case (state)
          IDLE: ;
          START: begin
            if (bit_done) begin
              state   <= DATA;
              bit_idx <= '0;
              tx      <= shift[0];
              shift   <= shift >> 1;
            end
          end
          DATA: begin
            if (bit_done) begin
              if (bit_idx == IDX_LAST) begin
                if (par_en) begin
                  state <= PARITY;
                  tx    <= par_bit;
                end else begin
                  state    <= STOP;
                  stop_idx <= 1'b0;
                  tx       <= 1'b1;
                end
              end else begin
                bit_idx <= bit_idx + IDX_W'(1);
                tx      <= shift[0];
                shift   <= shift >> 1;
              end
            end
          end
          PARITY: begin
            if (bit_done) begin
              state    <= STOP;
              stop_idx <= 1'b0;
              tx       <= 1'b1;
            end
          end
          STOP: begin
            if (bit_done) begin
              if (stop2 && !stop_idx) begin
                stop_idx <= 1'b1;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
                tx    <= 1'b1;
              end
            end
          end
          default: begin
            state <= IDLE;
            tx    <= 1'b1;
            busy  <= 1'b0;
          end
        endcase
      end

      // rdy is low whenever hold_full is set, so this never coincides with load.
      if (bus.vld_i && rdy) begin
        hold_data <= bus.dat_i;
        hold_full <= 1'b1;
        rdy       <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_prmcu_uart_tx.sv
// tb_prmcu_uart_tx: randomized and directed stimulus for prmcu_uart_tx, with a
// frame-level reference model (expected bit vector per frame, expected start
// cycle from transfer time and previous frame end) and a line monitor.
// CLKS_PER_BIT is reduced to keep the back-to-back run short; all expected
// lengths scale from CPB.
module tb_prmcu_uart_tx;

  localparam int CPB = 16;

  logic       clk;
  logic       rst;
  logic [1:0] parity_mode;
  logic       stop_bits;
  logic       tx;
  logic       busy;

  prmcu_uart_tx_if #(.N_BITS(8)) bus ();

  prmcu_uart_tx #(.CLKS_PER_BIT(CPB), .N_BITS(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .parity_mode_i (parity_mode),
    .stop_bits_i   (stop_bits),
    .tx_o          (tx),
    .busy_o        (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int         cyc = 0;
  logic [2:0] cfg_seen = 3'b000;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    cfg_seen <= {parity_mode, stop_bits};
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [7:0] d;
    int         xfer;
  } ent_t;

  ent_t        exp_q[$];
  int          frames_sent = 0;
  int          frames_done = 0;
  int          next_free = 0;
  bit          mon_en = 1'b0;
  logic [11:0] last_obs = '1;
  logic [11:0] prev_obs = '1;

  // Expected line levels of one frame, bit 0 = start bit.
  function automatic void build(input logic [7:0] d, input logic [1:0] m, input logic s2,
                                output logic [11:0] bits, output int nb);
    int p;
    int ones;
    p    = (m == 2'b01 || m == 2'b10) ? 1 : 0;
    ones = $countones(d);
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1 + i] = d[i];
    if (p == 1) bits[9] = (m == 2'b01) ? (ones % 2 == 1) : (ones % 2 == 0);
    nb = 1 + 8 + p + (s2 ? 2 : 1);
  endfunction

  initial begin : monitor
    bit          pending;
    ent_t        e;
    logic [11:0] ebits;
    logic [11:0] obits;
    int          nb, len, s, exp_s, lerr, berr;
    pending = 1'b0;
    forever begin
      if (!pending) @(negedge clk);
      pending = 1'b0;
      if (mon_en && !rst && tx === 1'b0) begin
        s = cyc;
        if (exp_q.size() == 0) begin
          chk("spurious_start", exp_q.size(), 1);
          repeat (12 * CPB) @(negedge clk);
        end else begin
          e     = exp_q.pop_front();
          exp_s = (e.xfer + 1 > next_free) ? e.xfer + 1 : next_free;
          chk("start_cycle", s, exp_s);
          chk("rdy_at_start", bus.rdy_o, 1);
          build(e.d, cfg_seen[2:1], cfg_seen[0], ebits, nb);
          len   = nb * CPB;
          lerr  = 0;
          berr  = 0;
          obits = '1;
          for (int i = 0; i < len; i++) begin
            if (i > 0) @(negedge clk);
            if (tx !== ebits[i / CPB]) lerr++;
            if (busy !== 1'b1) berr++;
            if (i % CPB == CPB / 2) obits[i / CPB] = tx;
          end
          chk("frame_bits", obits, ebits);
          chk("line_samples", lerr, 0);
          chk("busy_in_frame", berr, 0);
          next_free = s + len;
          prev_obs  = last_obs;
          last_obs  = obits;
          @(negedge clk);
          pending = 1'b1;
          chk("busy_after", busy, (exp_q.size() != 0 && exp_q[0].xfer + 1 <= next_free));
          frames_done++;
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge right after the transfer edge.
  task automatic send(input logic [7:0] d, input bit keep_vld, input bit track);
    int t;
    bus.dat_i = d;
    bus.vld_i = 1'b1;
    t = 0;
    while (bus.rdy_o !== 1'b1 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (bus.rdy_o !== 1'b1) begin
      chk("send_timeout", bus.rdy_o, 1);
      bus.vld_i = 1'b0;
      return;
    end
    if (track) begin
      exp_q.push_back('{d: d, xfer: cyc + 1});
      frames_sent++;
    end
    @(negedge clk);
    chk("rdy_drop", bus.rdy_o, 0);
    if (!keep_vld) bus.vld_i = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (frames_done != frames_sent && t < 40000) begin
      @(negedge clk);
      t++;
    end
    chk("drain", frames_done, frames_sent);
  endtask

  task automatic directed(input logic [7:0] d, input logic [1:0] m, input logic s2,
                          input int exp_len, input string tag);
    int n;
    int t;
    parity_mode = m;
    stop_bits   = s2;
    send(d, 1'b0, 1'b1);
    @(negedge clk);
    n = 0;
    t = 0;
    while (busy === 1'b1 && t < 4000) begin
      n++;
      t++;
      @(negedge clk);
    end
    chk({tag, "_busy_len"}, n, exp_len);
    drain();
  endtask

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    rst         = 1'b1;
    bus.vld_i   = 1'b0;
    bus.dat_i   = '0;
    parity_mode = 2'b00;
    stop_bits   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_rdy", bus.rdy_o, 1);
    chk("rst_busy", busy, 0);
    rst    = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    directed(8'h54, 2'b00, 1'b0, 10 * CPB, "single_54");
    chk("single_54_data", last_obs[8:1], 8'h54);
    directed(8'h07, 2'b01, 1'b0, 11 * CPB, "even_07");
    chk("even_07_par", last_obs[9], 1);
    directed(8'h00, 2'b10, 1'b0, 11 * CPB, "odd_00");
    chk("odd_00_par", last_obs[9], 1);
    directed(8'h01, 2'b10, 1'b0, 11 * CPB, "odd_01");
    chk("odd_01_par", last_obs[9], 0);
    directed(8'hA5, 2'b00, 1'b1, 11 * CPB, "stop2_a5");
    chk("stop2_a5_data", last_obs[8:1], 8'hA5);

    // back-to-back with vld held and random config per byte
    for (int i = 0; i < 100; i++) begin
      parity_mode = 2'($urandom_range(0, 3));
      stop_bits   = 1'($urandom_range(0, 1));
      send(8'($urandom_range(0, 255)), 1'b1, 1'b1);
    end
    bus.vld_i = 1'b0;
    drain();

    // config change during byte 0 data bits applies only to byte 1
    parity_mode = 2'b00;
    stop_bits   = 1'b0;
    send(8'h03, 1'b1, 1'b1);
    send(8'h03, 1'b0, 1'b1);
    repeat (3 * CPB) @(negedge clk);
    parity_mode = 2'b01;
    drain();
    chk("cfg_b0_no_parity", prev_obs[9], 1);
    chk("cfg_b1_even_parity", last_obs[9], 0);

    // reset in the middle of data bit 3
    mon_en      = 1'b0;
    parity_mode = 2'b00;
    stop_bits   = 1'b0;
    send(8'h00, 1'b0, 1'b0);
    repeat (4 * CPB + CPB / 2 + 1) @(negedge clk);
    chk("pre_rst_tx_low", tx, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_tx", tx, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rdy", bus.rdy_o, 1);
    rst       = 1'b0;
    next_free = 0;
    mon_en    = 1'b1;
    @(negedge clk);
    directed(8'hC3, 2'b10, 1'b1, 12 * CPB, "post_rst");
    chk("post_rst_data", last_obs[8:1], 8'hC3);

    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
